lcplc_input_sequencer: RTL and testbench
========================================

Name: lcplc_input_sequencer

Overview:
Front-end controller for the LCPLC coder. It takes a raw AXI-Stream of samples and a per-image configuration command. It tags each sample with the x_last_r/s/b/i flags the coder consumes, and holds cfg_quant_shift/cfg_threshold stable for the whole image. It sits directly in front of the LCPLC instance. It replaces the per-flag file generators used in simulation with a synthesizable sequencer.

Parameters:
DATA_WIDTH, 16, sample width.
MAX_SLICE_SIZE_LOG, 8, log2 of max block width and max block height.
BAND_WIDTH, 12, width of band-count field.
BLOCK_WIDTH, 16, width of block-count field.
QUANTIZER_SHIFT_WIDTH, 4, quantizer shift field width.
THRESHOLD_WIDTH, 64, threshold field width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  start-of-image command valid
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_cols_m1  in  MAX_SLICE_SIZE_LOG  block width minus 1
cmd_rows_m1  in  MAX_SLICE_SIZE_LOG  block height minus 1
cmd_bands_m1  in  BAND_WIDTH  bands minus 1
cmd_blocks_m1  in  BLOCK_WIDTH  blocks in image minus 1
cmd_quant_shift  in  QUANTIZER_SHIFT_WIDTH  quantizer shift for image
cmd_threshold  in  THRESHOLD_WIDTH  threshold for image
s_valid/s_ready  in/out  1  raw sample handshake
s_data  in  DATA_WIDTH  raw sample
x_valid/x_ready  out/in  1  to coder
x_data  out  DATA_WIDTH  sample to coder
x_last_r, x_last_s, x_last_b, x_last_i  out  1 each  flags to coder
cfg_quant_shift  out  QUANTIZER_SHIFT_WIDTH  latched shift
cfg_threshold  out  THRESHOLD_WIDTH  latched threshold
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at end of image

Behaviour:
- Sample order is block-major, then band, then row, then column. Counters col, row, band, blk are all zero-based.
- Flag definitions, evaluated on the accepted sample:
  - last_r = (col==cols_m1).
  - last_s = last_r & (row==rows_m1).
  - last_b = last_s & (band==bands_m1).
  - last_i = last_b & (blk==blocks_m1).
- Counter advance on s accept: col wraps to 0 on last_r and increments row. Row wraps on last_s and increments band. Band wraps on last_b and increments blk.
- FSM:
  - IDLE: cmd_ready=1, s_ready=0. On cmd_valid, latch all cmd_* fields, zero the counters, go to RUN.
  - RUN: cmd_ready=0. Accepting a sample with last_i moves to DRAIN. That sample is the last one accepted.
  - DRAIN: s_ready=0. When the output register is empty (or empties this cycle via x_ready), pulse done and go to IDLE.
- Output register: single stage, holding data and flags.
  - s_ready = (state==RUN) & (!x_valid | x_ready).
  - Full throughput, 1 sample/cycle; latency 1 cycle from s accept to x_valid.
  - x_data and flags are stable while x_valid & !x_ready.
- cfg_quant_shift/cfg_threshold update only on command accept and hold until the next command, including through IDLE.
- Degenerate geometry: all *_m1 = 0 gives exactly one sample with all four flags high.
- A command presented in RUN/DRAIN stalls (cmd_ready=0); it is never dropped.
- done and cmd accept never occur in the same cycle; IDLE is entered the cycle after done.
- Reset (at any time, including mid-image):
  - state=IDLE and counters=0.
  - x_valid=0 and all x_last_*=0; x_data=0.
  - cfg_quant_shift=0 and cfg_threshold=0.
  - busy=0, done=0, cmd_ready=0 during reset, then 1 the following cycle.
  - s_ready=0.
  - Any partial image is discarded.

Optional Feature:
LCPLC_SEQ_CHECK_EN:
- When defined, the block adds an input s_last (upstream end-of-image marker) and an output err_last (sticky).
- err_last sets when an accepted sample has s_last != generated last_i. It clears only on reset or command accept.
- Generated flags are always used; s_last never alters sequencing.
- When not defined, neither port exists and no check logic is built.

Decomposition:
- Package lcplc_seq_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - a struct for latched geometry and config;
  - a struct for the output beat (data plus 4 flags).
- One natural sub-module: lcplc_seq_counter. It holds the nested col/row/band/blk counters with wrap logic and flag generation, driven by an advance strobe and a clear strobe.

Test Plan:
1. cols=2, rows=2, bands=2, blocks=1 (m1=1,1,1,0), x_ready=1, samples 0..7 → last_r on samples 1,3,5,7; last_s on 3,7; last_b on 7; last_i on 7; done one cycle after sample 7 leaves.
2. Same geometry, x_ready toggling 1-of-4 cycles → no sample lost or duplicated; data/flags stable while stalled; s_ready low whenever output is full and x_ready=0.
3. All m1=0, two back-to-back commands with shift 3 then 5 → each image is 1 sample with all flags set; cfg_quant_shift reads 3 during image 1 and 5 only after the second cmd accept; second cmd_ready held low until IDLE.
4. cols=4, rows=1, bands=3, blocks=2 (24 samples), assert rst after sample 10 → outputs reset to 0 next cycle; new command restarts counting at col=0 with correct flags.
5. s_valid held high in IDLE before any command → s_ready=0, nothing passed to x.
6. (LCPLC_SEQ_CHECK_EN) geometry from scenario 1 with s_last wrongly on sample 5 → err_last high from the cycle after sample 5 and held; cleared by the next cmd accept.

Source files
------------

// File: rtl/lcplc_seq_pkg.sv
// rtl/lcplc_seq_pkg.sv - shared types for the LCPLC input sequencer
// Purpose: default field widths, FSM state encoding, latched image
//          configuration and the registered output beat.
// Ports:   none (package).
package lcplc_seq_pkg;

  localparam int SEQ_DATA_WIDTH        = 16;
  localparam int SEQ_SLICE_SIZE_LOG    = 8;
  localparam int SEQ_BAND_WIDTH        = 12;
  localparam int SEQ_BLOCK_WIDTH       = 16;
  localparam int SEQ_QUANT_SHIFT_WIDTH = 4;
  localparam int SEQ_THRESHOLD_WIDTH   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // Geometry and coder configuration captured on command accept.
  typedef struct packed {
    logic [SEQ_SLICE_SIZE_LOG-1:0]    cols_m1;
    logic [SEQ_SLICE_SIZE_LOG-1:0]    rows_m1;
    logic [SEQ_BAND_WIDTH-1:0]        bands_m1;
    logic [SEQ_BLOCK_WIDTH-1:0]       blocks_m1;
    logic [SEQ_QUANT_SHIFT_WIDTH-1:0] quant_shift;
    logic [SEQ_THRESHOLD_WIDTH-1:0]   threshold;
  } seq_cfg_t;

  // One sample as presented to the coder.
  typedef struct packed {
    logic [SEQ_DATA_WIDTH-1:0] data;
    logic                      last_r;
    logic                      last_s;
    logic                      last_b;
    logic                      last_i;
  } seq_beat_t;

endpackage

// File: rtl/lcplc_seq_counter.sv
// rtl/lcplc_seq_counter.sv - nested col/row/band/blk counters with last-flag generation
// Purpose: tracks the position of the next sample inside the image
//          (block-major, then band, row, column) and flags the ends of
//          row, slice, band-set and image for that sample.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear             zero all counters (new image)
//   advance           one sample accepted; step the counters
//   cols_m1..blocks_m1 image geometry, each minus 1
//   last_r/s/b/i      flags for the sample at the current position
module lcplc_seq_counter #(
  parameter int MAX_SLICE_SIZE_LOG = 8,
  parameter int BAND_WIDTH         = 12,
  parameter int BLOCK_WIDTH        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          advance,
  input  logic [MAX_SLICE_SIZE_LOG-1:0] cols_m1,
  input  logic [MAX_SLICE_SIZE_LOG-1:0] rows_m1,
  input  logic [BAND_WIDTH-1:0]         bands_m1,
  input  logic [BLOCK_WIDTH-1:0]        blocks_m1,
  output logic                          last_r,
  output logic                          last_s,
  output logic                          last_b,
  output logic                          last_i
);

  logic [MAX_SLICE_SIZE_LOG-1:0] col;
  logic [MAX_SLICE_SIZE_LOG-1:0] row;
  logic [BAND_WIDTH-1:0]         band;
  logic [BLOCK_WIDTH-1:0]        blk;

  // Each flag qualifies the next outer one, so a higher-level end can
  // only occur on the last column of the last row, and so on.
  assign last_r = (col == cols_m1);
  assign last_s = last_r & (row == rows_m1);
  assign last_b = last_s & (band == bands_m1);
  assign last_i = last_b & (blk == blocks_m1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col  <= '0;
      row  <= '0;
      band <= '0;
      blk  <= '0;
    end else if (advance) begin
      if (!last_r) begin
        col <= col + 1'b1;
      end else begin
        col <= '0;
        if (!last_s) begin
          row <= row + 1'b1;
        end else begin
          row <= '0;
          if (!last_b) begin
            band <= band + 1'b1;
          end else begin
            band <= '0;
            blk  <= last_i ? '0 : blk + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/lcplc_input_sequencer.sv
// rtl/lcplc_input_sequencer.sv - LCPLC front-end: image command, sample tagging, config hold
// Purpose: accepts one command per image, tags each raw sample with the
//          x_last_r/s/b/i flags the coder expects and holds the quantizer
//          shift and threshold stable for the whole image.
// Optional: define LCPLC_SEQ_CHECK_EN to add s_last (upstream end-of-image
//           marker) and sticky err_last (s_last disagreed with generated last_i).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      image command handshake
//   cmd_*                    geometry (minus 1), quant shift, threshold
//   s_valid/s_ready/s_data   raw sample stream in
//   x_valid/x_ready/x_data   tagged sample stream to the coder
//   x_last_r/s/b/i           end of row / slice / band-set / image
//   cfg_quant_shift/threshold configuration latched on command accept
//   busy                     high outside IDLE
//   done                     one-cycle pulse when the last sample leaves
module lcplc_input_sequencer
  import lcplc_seq_pkg::*;
#(
  parameter int DATA_WIDTH            = SEQ_DATA_WIDTH,
  parameter int MAX_SLICE_SIZE_LOG    = SEQ_SLICE_SIZE_LOG,
  parameter int BAND_WIDTH            = SEQ_BAND_WIDTH,
  parameter int BLOCK_WIDTH           = SEQ_BLOCK_WIDTH,
  parameter int QUANTIZER_SHIFT_WIDTH = SEQ_QUANT_SHIFT_WIDTH,
  parameter int THRESHOLD_WIDTH       = SEQ_THRESHOLD_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [MAX_SLICE_SIZE_LOG-1:0]    cmd_cols_m1,
  input  logic [MAX_SLICE_SIZE_LOG-1:0]    cmd_rows_m1,
  input  logic [BAND_WIDTH-1:0]            cmd_bands_m1,
  input  logic [BLOCK_WIDTH-1:0]           cmd_blocks_m1,
  input  logic [QUANTIZER_SHIFT_WIDTH-1:0] cmd_quant_shift,
  input  logic [THRESHOLD_WIDTH-1:0]       cmd_threshold,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DATA_WIDTH-1:0]            s_data,
  output logic                             x_valid,
  input  logic                             x_ready,
  output logic [DATA_WIDTH-1:0]            x_data,
  output logic                             x_last_r,
  output logic                             x_last_s,
  output logic                             x_last_b,
  output logic                             x_last_i,
  output logic [QUANTIZER_SHIFT_WIDTH-1:0] cfg_quant_shift,
  output logic [THRESHOLD_WIDTH-1:0]       cfg_threshold,
  output logic                             busy,
  output logic                             done
`ifdef LCPLC_SEQ_CHECK_EN
  ,
  input  logic                             s_last,
  output logic                             err_last
`endif
);

  seq_state_t state;
  seq_state_t state_nxt;
  seq_cfg_t   cfg;
  seq_beat_t  beat;

  logic out_free;
  logic cmd_acc;
  logic s_acc;
  logic gen_last_r;
  logic gen_last_s;
  logic gen_last_b;
  logic gen_last_i;

  // Output register can take a new sample if empty or emptying now.
  assign out_free = !x_valid || x_ready;
  assign cmd_acc  = cmd_valid && cmd_ready;
  assign s_acc    = s_valid && s_ready;

  lcplc_seq_counter #(
    .MAX_SLICE_SIZE_LOG(MAX_SLICE_SIZE_LOG),
    .BAND_WIDTH        (BAND_WIDTH),
    .BLOCK_WIDTH       (BLOCK_WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cmd_acc),
    .advance  (s_acc),
    .cols_m1  (cfg.cols_m1),
    .rows_m1  (cfg.rows_m1),
    .bands_m1 (cfg.bands_m1),
    .blocks_m1(cfg.blocks_m1),
    .last_r   (gen_last_r),
    .last_s   (gen_last_s),
    .last_b   (gen_last_b),
    .last_i   (gen_last_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs are gated by rst so nothing is accepted or
  // signalled while reset is held, whatever state is still registered.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    s_ready   = 1'b0;
    done      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          s_ready = out_free;
          if (s_valid && out_free && gen_last_i) begin
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (out_free) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg <= '0;
    end else if (cmd_acc) begin
      cfg <= '{cols_m1:     cmd_cols_m1,
               rows_m1:     cmd_rows_m1,
               bands_m1:    cmd_bands_m1,
               blocks_m1:   cmd_blocks_m1,
               quant_shift: cmd_quant_shift,
               threshold:   cmd_threshold};
    end
  end

  // Beat contents are only rewritten on accept, which keeps them stable
  // while the coder stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_valid <= 1'b0;
      beat    <= '0;
    end else if (s_acc) begin
      x_valid <= 1'b1;
      beat    <= '{data:   s_data,
                   last_r: gen_last_r,
                   last_s: gen_last_s,
                   last_b: gen_last_b,
                   last_i: gen_last_i};
    end else if (x_ready) begin
      x_valid <= 1'b0;
    end
  end

  assign x_data          = beat.data;
  assign x_last_r        = beat.last_r;
  assign x_last_s        = beat.last_s;
  assign x_last_b        = beat.last_b;
  assign x_last_i        = beat.last_i;
  assign cfg_quant_shift = cfg.quant_shift;
  assign cfg_threshold   = cfg.threshold;

`ifdef LCPLC_SEQ_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst || cmd_acc) begin
      err_last <= 1'b0;
    end else if (s_acc && (s_last != gen_last_i)) begin
      err_last <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lcplc_input_sequencer.sv
// tb/tb_lcplc_input_sequencer.sv - self-checking bench for lcplc_input_sequencer
module tb_lcplc_input_sequencer;

  localparam int DW = 16;
  localparam int MS = 8;
  localparam int BW = 12;
  localparam int KW = 16;
  localparam int QW = 4;
  localparam int TW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [MS-1:0] cmd_cols_m1;
  logic [MS-1:0] cmd_rows_m1;
  logic [BW-1:0] cmd_bands_m1;
  logic [KW-1:0] cmd_blocks_m1;
  logic [QW-1:0] cmd_quant_shift;
  logic [TW-1:0] cmd_threshold;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          x_valid;
  logic          x_ready;
  logic [DW-1:0] x_data;
  logic          x_last_r;
  logic          x_last_s;
  logic          x_last_b;
  logic          x_last_i;
  logic [QW-1:0] cfg_quant_shift;
  logic [TW-1:0] cfg_threshold;
  logic          busy;
  logic          done;
  logic          s_last;
`ifdef LCPLC_SEQ_CHECK_EN
  logic          err_last;
`endif

  always #5 clk = ~clk;

  lcplc_input_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_cols_m1    (cmd_cols_m1),
    .cmd_rows_m1    (cmd_rows_m1),
    .cmd_bands_m1   (cmd_bands_m1),
    .cmd_blocks_m1  (cmd_blocks_m1),
    .cmd_quant_shift(cmd_quant_shift),
    .cmd_threshold  (cmd_threshold),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .x_valid        (x_valid),
    .x_ready        (x_ready),
    .x_data         (x_data),
    .x_last_r       (x_last_r),
    .x_last_s       (x_last_s),
    .x_last_b       (x_last_b),
    .x_last_i       (x_last_i),
    .cfg_quant_shift(cfg_quant_shift),
    .cfg_threshold  (cfg_threshold),
    .busy           (busy),
    .done           (done)
`ifdef LCPLC_SEQ_CHECK_EN
    ,
    .s_last         (s_last),
    .err_last       (err_last)
`endif
  );

  logic [3:0] x_flags;
  assign x_flags = {x_last_r, x_last_s, x_last_b, x_last_i};

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    flags;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int            c;
    int            r;
    int            b;
    int            k;
    logic [QW-1:0] shift;
    logic [TW-1:0] thr;
    int            mode;
    int            n_exp;
  } vec_t;
  vec_t vt[5];

  int            c_n = 1, r_n = 1, b_n = 1, k_n = 1;
  int            sidx = 0;
  int            out_cnt = 0;
  int            done_cnt = 0;
  int            cyc = 0;
  int            ready_mode = 0;
  logic [QW-1:0] exp_shift = '0;
  logic [TW-1:0] exp_thr = '0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [3:0]    prev_flags = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference flags from the sample's index within the image.
  function automatic logic [3:0] model_flags(input int idx);
    int col, row, band, blk;
    logic lr, ls, lb, li;
    col  = idx % c_n;
    row  = (idx / c_n) % r_n;
    band = (idx / (c_n * r_n)) % b_n;
    blk  = idx / (c_n * r_n * b_n);
    lr = (col == c_n - 1);
    ls = lr && (row == r_n - 1);
    lb = ls && (band == b_n - 1);
    li = lb && (blk == k_n - 1);
    return {lr, ls, lb, li};
  endfunction

  // Monitor / scoreboard: everything sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      sb.delete();
      sidx       = 0;
      prev_stall = 1'b0;
      exp_shift  = '0;
      exp_thr    = '0;
    end else begin
      if (busy) begin
        chk("cfg_shift", 64'(cfg_quant_shift), 64'(exp_shift));
        chk("cfg_thr", cfg_threshold, exp_thr);
      end
      if (prev_stall) begin
        chk("stall_data", 64'(x_data), 64'(prev_data));
        chk("stall_flags", 64'(x_flags), 64'(prev_flags));
      end
      if (x_valid && !x_ready) chk("s_ready_when_full", 64'(s_ready), 64'(0));
      if (cmd_valid && busy) chk("cmd_ready_when_busy", 64'(cmd_ready), 64'(0));
      if (done) begin
        done_cnt++;
        chk("done_with_cmd_ready", 64'(cmd_ready), 64'(0));
      end
      if (x_valid && x_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", x_data);
        end else begin
          e = sb.pop_front();
          chk("x_data", 64'(x_data), 64'(e.data));
          chk("x_flags", 64'(x_flags), 64'(e.flags));
          out_cnt++;
        end
      end
      if (done) chk("done_queue_empty", 64'(sb.size()), 64'(0));
      if (s_valid && s_ready) begin
        sb.push_back('{data: s_data, flags: model_flags(sidx)});
        sidx++;
      end
      if (cmd_valid && cmd_ready) begin
        exp_shift = cmd_quant_shift;
        exp_thr   = cmd_threshold;
        c_n  = int'(cmd_cols_m1) + 1;
        r_n  = int'(cmd_rows_m1) + 1;
        b_n  = int'(cmd_bands_m1) + 1;
        k_n  = int'(cmd_blocks_m1) + 1;
        sidx = 0;
      end
      prev_stall = x_valid && !x_ready;
      prev_data  = x_data;
      prev_flags = x_flags;
    end
  end

  // Coder back-pressure patterns.
  initial begin
    x_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       x_ready = 1'b1;
        1:       x_ready = (cyc % 4 == 0);
        default: x_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic send_cmd(input int c, input int r, input int b, input int k,
                          input logic [QW-1:0] sh, input logic [TW-1:0] th);
    bit acc = 0;
    cmd_cols_m1     = MS'(c);
    cmd_rows_m1     = MS'(r);
    cmd_bands_m1    = BW'(b);
    cmd_blocks_m1   = KW'(k);
    cmd_quant_shift = sh;
    cmd_threshold   = th;
    cmd_valid       = 1'b1;
    for (int t = 0; t < 400 && !acc; t++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("cmd_accepted", 64'(acc), 64'(1));
  endtask

  task automatic send_sample(input logic [DW-1:0] d, input logic last);
    bit acc = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int t = 0; t < 400 && !acc; t++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!acc) chk("sample_accepted", 64'(acc), 64'(1));
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("done_seen", 64'(done_cnt > d0), 64'(1));
  endtask

  task automatic run_image(input vec_t v, input logic [DW-1:0] base);
    int o0, d0;
    o0 = out_cnt;
    d0 = done_cnt;
    ready_mode = v.mode;
    send_cmd(v.c, v.r, v.b, v.k, v.shift, v.thr);
    for (int i = 0; i < v.n_exp; i++) send_sample(base + DW'(i), i == v.n_exp - 1);
    wait_done(d0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("n_out", 64'(out_cnt - o0), 64'(v.n_exp));
    chk("n_done", 64'(done_cnt - d0), 64'(1));
    chk("idle_after", 64'(busy), 64'(0));
    ready_mode = 0;
  endtask

  initial begin
    int d0, o0;
    vt[0] = '{c: 1, r: 1, b: 1, k: 0, shift: 4'd2,  thr: 64'h1234,                mode: 0, n_exp: 8};
    vt[1] = '{c: 1, r: 1, b: 1, k: 0, shift: 4'd7,  thr: 64'hDEAD_BEEF_0123_4567, mode: 1, n_exp: 8};
    vt[2] = '{c: 2, r: 1, b: 0, k: 1, shift: 4'd9,  thr: 64'h55,                  mode: 2, n_exp: 12};
    vt[3] = '{c: 0, r: 2, b: 1, k: 2, shift: 4'd15, thr: 64'hFFFF_FFFF_FFFF_FFFF, mode: 0, n_exp: 18};
    vt[4] = '{c: 3, r: 0, b: 2, k: 1, shift: 4'd4,  thr: 64'h0BAD_F00D,           mode: 0, n_exp: 24};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_cols_m1 = '0;
    cmd_rows_m1 = '0;
    cmd_bands_m1 = '0;
    cmd_blocks_m1 = '0;
    cmd_quant_shift = '0;
    cmd_threshold = '0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;

    // Reset state.
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_x_valid", 64'(x_valid), 64'(0));
    chk("rst_x_data", 64'(x_data), 64'(0));
    chk("rst_x_flags", 64'(x_flags), 64'(0));
    chk("rst_cfg_shift", 64'(cfg_quant_shift), 64'(0));
    chk("rst_cfg_thr", cfg_threshold, 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));
    @(posedge clk);
    #1;

    // s_valid in IDLE must not pass anything.
    s_valid = 1'b1;
    s_data  = 16'hAAAA;
    repeat (5) begin
      @(negedge clk);
      chk("idle_s_ready", 64'(s_ready), 64'(0));
      chk("idle_x_valid", 64'(x_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;

    // Table of images.
    for (int v = 0; v < 4; v++) run_image(vt[v], DW'(16'h1000 * (v + 1)));

    // Back-to-back degenerate images; second command stalls until IDLE.
    d0 = done_cnt;
    o0 = out_cnt;
    send_cmd(0, 0, 0, 0, 4'd3, 64'h33);
    @(negedge clk);
    chk("b2b_shift_1", 64'(cfg_quant_shift), 64'(3));
    @(posedge clk);
    #1;
    fork
      send_cmd(0, 0, 0, 0, 4'd5, 64'h55);
      send_sample(16'h0F0F, 1'b1);
    join
    @(negedge clk);
    chk("b2b_shift_2", 64'(cfg_quant_shift), 64'(5));
    chk("b2b_done_1", 64'(done_cnt - d0), 64'(1));
    @(posedge clk);
    #1;
    send_sample(16'hF0F0, 1'b1);
    wait_done(d0 + 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_outputs", 64'(out_cnt - o0), 64'(2));
    chk("b2b_done_2", 64'(done_cnt - d0), 64'(2));

    // Reset mid-image after 11 samples, then a clean restart.
    send_cmd(vt[4].c, vt[4].r, vt[4].b, vt[4].k, vt[4].shift, vt[4].thr);
    for (int i = 0; i < 11; i++) send_sample(DW'(16'h7700 + i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("midrst_s_ready", 64'(s_ready), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_x_valid", 64'(x_valid), 64'(0));
    chk("midrst_x_data", 64'(x_data), 64'(0));
    chk("midrst_x_flags", 64'(x_flags), 64'(0));
    chk("midrst_cfg_shift", 64'(cfg_quant_shift), 64'(0));
    chk("midrst_cfg_thr", cfg_threshold, 64'(0));
    chk("midrst_cmd_ready_after", 64'(cmd_ready), 64'(1));
    @(posedge clk);
    #1;
    run_image(vt[4], 16'h8800);

`ifdef LCPLC_SEQ_CHECK_EN
    // Wrong upstream marker on sample 5 of an 8-sample image.
    send_cmd(1, 1, 1, 0, 4'd1, 64'h1);
    for (int i = 0; i < 8; i++) begin
      send_sample(DW'(16'h9900 + i), i == 5);
      if (i == 4) chk("err_before", 64'(err_last), 64'(0));
      if (i == 5) chk("err_set", 64'(err_last), 64'(1));
    end
    wait_done(done_cnt);
    @(posedge clk);
    #1;
    chk("err_held", 64'(err_last), 64'(1));
    send_cmd(0, 0, 0, 0, 4'd2, 64'h2);
    chk("err_cleared", 64'(err_last), 64'(0));
    send_sample(16'hABCD, 1'b1);
    chk("err_stays_clear", 64'(err_last), 64'(0));
    wait_done(done_cnt);
`endif

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("final_queue_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
